// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, fetches one word per instruction over
// a req/ready handshake, issues it to the datapath and computes the next PC
// from the Jump/Branch/Zero decisions once execution completes.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        exec_done,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        Zero,
    output logic [31:0] instr,
    output logic [5:0]  Opcode,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        halted,
    output logic [31:0] retired
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned OPW    = 6;
    localparam int unsigned IMMW   = 16;
    localparam int unsigned JIDXW  = 26;
    localparam logic [OPW-1:0]  OP_HALT  = 6'h3F;
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
    // Low address bits are forced to zero so the PC stays word aligned.
    localparam logic [XLEN-1:0] PC_RESET = {RESET_PC[XLEN-1:2], 2'b00};

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_ISSUE  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_pc_plus4;
    logic [XLEN-1:0]   r_instr;
    logic [XLEN-1:0]   r_retired;
    logic              r_req;
    logic              r_valid;
    logic              r_halted;

    logic [XLEN-1:0]   w_pc_next;
    logic [XLEN-1:0]   w_pc_plus4_next;
    logic [XLEN-1:0]   w_instr_next;
    logic [XLEN-1:0]   w_retired_next;
    logic              w_req_next;
    logic              w_valid_next;
    logic              w_halted_next;

    logic [XLEN-1:0]   w_branch_off;
    logic [XLEN-1:0]   w_branch_target;
    logic [XLEN-1:0]   w_jump_target;
    logic [XLEN-1:0]   w_target;
    logic [OPW-1:0]    w_fetch_op;

    // Next-PC selection: jump beats a taken branch, which beats sequential.
    always_comb begin
        w_branch_off    = {{(XLEN-IMMW-2){r_instr[IMMW-1]}}, r_instr[IMMW-1:0], 2'b00};
        w_branch_target = r_pc_plus4 + w_branch_off;
        w_jump_target   = {r_pc_plus4[XLEN-1:XLEN-4], r_instr[JIDXW-1:0], 2'b00};
        w_target        = r_pc_plus4;
        if (Jump) begin
            w_target = w_jump_target;
        end else if (Branch && Zero) begin
            w_target = w_branch_target;
        end
    end

    // Next-state and next-register values for the fetch/issue/halt sequence.
    always_comb begin
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_instr_next   = r_instr;
        w_retired_next = r_retired;
        w_fetch_op     = imem_rdata[XLEN-1:XLEN-OPW];

        case (r_state)
            S_FETCH: begin
                if (imem_ready) begin
                    w_instr_next = imem_rdata;
                    w_state_next = (w_fetch_op == OP_HALT) ? S_HALTED : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (exec_done) begin
                    w_pc_next      = w_target;
                    w_retired_next = r_retired + XLEN'(1);
                    w_state_next   = S_FETCH;
                end
            end
            S_HALTED: begin
                w_state_next = S_HALTED;
            end
            default: begin
                w_state_next = S_FETCH;
            end
        endcase

        w_pc_plus4_next = w_pc_next + PC_STEP;
        w_req_next      = (w_state_next == S_FETCH);
        w_valid_next    = (w_state_next == S_ISSUE);
        w_halted_next   = (w_state_next == S_HALTED);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath and status registers; reset abandons any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= PC_RESET;
            r_pc_plus4 <= PC_RESET + PC_STEP;
            r_instr    <= '0;
            r_retired  <= '0;
            r_req      <= 1'b1;
            r_valid    <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_pc       <= w_pc_next;
            r_pc_plus4 <= w_pc_plus4_next;
            r_instr    <= w_instr_next;
            r_retired  <= w_retired_next;
            r_req      <= w_req_next;
            r_valid    <= w_valid_next;
            r_halted   <= w_halted_next;
        end
    end

    // The request is held off while reset is asserted so memory sees no fetch
    // in the reset cycle, and is raised in the first cycle after release.
    assign imem_req    = r_req & ~rst;
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign Opcode      = r_instr[XLEN-1:XLEN-OPW];
    assign instr_valid = r_valid;
    assign pc          = r_pc;
    assign pc_plus4    = r_pc_plus4;
    assign halted      = r_halted;
    assign retired     = r_retired;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a table of fetch/execute steps with
// hand-computed next PCs, followed by halt and reset corner sequences.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        exec_done;
    logic        Branch;
    logic        Jump;
    logic        Zero;
    logic [31:0] instr;
    logic [5:0]  Opcode;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        halted;
    logic [31:0] retired;

    int n_checks;
    int n_fail;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .exec_done   (exec_done),
        .Branch      (Branch),
        .Jump        (Jump),
        .Zero        (Zero),
        .instr       (instr),
        .Opcode      (Opcode),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .halted      (halted),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        int          waits;
        int          delay;
        logic        br;
        logic        jmp;
        logic        zero;
        logic [31:0] exp_next;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vec [NVEC];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] exp_ret;
        logic [31:0] rd;
        vec_t        v;

        n_checks = 0;
        n_fail   = 0;

        vec[0]  = '{32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0004};
        vec[1]  = '{32'h0000_0020, 3, 1, 1'b0, 1'b0, 1'b0, 32'h0000_0008};
        vec[2]  = '{32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b1, 32'h0000_000C};
        vec[3]  = '{32'h0000_0020, 1, 2, 1'b0, 1'b0, 1'b0, 32'h0000_0010};
        vec[4]  = '{32'h4000_FFFE, 0, 0, 1'b1, 1'b0, 1'b1, 32'h0000_000C};
        vec[5]  = '{32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0010};
        vec[6]  = '{32'h4000_FFFE, 0, 0, 1'b1, 1'b0, 1'b0, 32'h0000_0014};
        vec[7]  = '{32'h0800_0008, 0, 0, 1'b0, 1'b1, 1'b0, 32'h0000_0020};
        vec[8]  = '{32'h8000_0040, 0, 0, 1'b1, 1'b1, 1'b1, 32'h0000_0100};
        vec[9]  = '{32'h1000_FFBB, 0, 0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF0};
        vec[10] = '{32'h0800_0000, 0, 0, 1'b0, 1'b1, 1'b0, 32'hF000_0000};
        vec[11] = '{32'h8000_0040, 0, 0, 1'b1, 1'b1, 1'b1, 32'hF000_0100};
        vec[12] = '{32'h0BFF_FFFF, 0, 0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC};
        vec[13] = '{32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0000};
        vec[14] = '{32'h1000_FFFE, 0, 0, 1'b1, 1'b0, 1'b0, 32'h0000_0004};

        rst        = 1'b1;
        imem_rdata = '0;
        imem_ready = 1'b0;
        exec_done  = 1'b0;
        Branch     = 1'b0;
        Jump       = 1'b0;
        Zero       = 1'b0;

        #1;
        check("req_in_reset_initial", 32'(imem_req), 32'h0);
        tick();
        tick();
        check("reset_pc",        pc,                 32'h0);
        check("reset_pc_plus4",  pc_plus4,           32'h4);
        check("reset_instr",     instr,              32'h0);
        check("reset_valid",     32'(instr_valid),   32'h0);
        check("reset_halted",    32'(halted),        32'h0);
        check("reset_retired",   retired,            32'h0);
        check("req_in_reset",    32'(imem_req),      32'h0);
        rst = 1'b0;
        #1;
        check("req_after_release", 32'(imem_req), 32'h1);
        check("addr_after_release", imem_addr, 32'h0);

        exp_pc  = 32'h0;
        exp_ret = 32'h0;
        for (int i = 0; i < NVEC; i++) begin
            v  = vec[i];
            rd = v.rdata;
            check("fetch_req",  32'(imem_req), 32'h1);
            check("fetch_addr", imem_addr,     exp_pc);
            for (int w = 0; w < v.waits; w++) begin
                imem_ready = 1'b0;
                exec_done  = 1'b1;
                tick();
                check("wait_addr",  imem_addr,         exp_pc);
                check("wait_req",   32'(imem_req),     32'h1);
                check("wait_valid", 32'(instr_valid),  32'h0);
                check("wait_retired", retired,         exp_ret);
            end
            exec_done  = 1'b0;
            imem_ready = 1'b1;
            imem_rdata = v.rdata;
            tick();
            imem_ready = 1'b0;
            check("issue_valid",  32'(instr_valid), 32'h1);
            check("issue_req",    32'(imem_req),    32'h0);
            check("issue_instr",  instr,            v.rdata);
            check("issue_opcode", 32'(Opcode),      32'(rd[31:26]));
            check("issue_pc",     pc,               exp_pc);
            check("issue_pc4",    pc_plus4,         exp_pc + 32'd4);
            for (int d = 0; d < v.delay; d++) begin
                imem_ready = 1'b1;
                imem_rdata = 32'hFC00_0000;
                tick();
                check("hold_instr", instr,            v.rdata);
                check("hold_valid", 32'(instr_valid), 32'h1);
            end
            imem_ready = 1'b0;
            exec_done  = 1'b1;
            Branch     = v.br;
            Jump       = v.jmp;
            Zero       = v.zero;
            tick();
            exec_done = 1'b0;
            Branch    = 1'b0;
            Jump      = 1'b0;
            Zero      = 1'b0;
            exp_ret   = exp_ret + 32'd1;
            check("next_addr",    imem_addr,        v.exp_next);
            check("next_pc",      pc,               v.exp_next);
            check("next_req",     32'(imem_req),    32'h1);
            check("next_valid",   32'(instr_valid), 32'h0);
            check("next_retired", retired,          exp_ret);
            exp_pc = v.exp_next;
        end

        // Halt: fetch a halt opcode, then verify everything is frozen.
        check("halt_fetch_addr", imem_addr, 32'h4);
        imem_ready = 1'b1;
        imem_rdata = 32'hFC00_0000;
        tick();
        imem_ready = 1'b0;
        check("halt_flag",   32'(halted),      32'h1);
        check("halt_req",    32'(imem_req),    32'h0);
        check("halt_valid",  32'(instr_valid), 32'h0);
        check("halt_instr",  instr,            32'hFC00_0000);
        check("halt_opcode", 32'(Opcode),      32'h3F);
        for (int k = 0; k < 3; k++) begin
            exec_done  = 1'b1;
            imem_ready = 1'b1;
            imem_rdata = 32'h0000_0020;
            tick();
            check("halted_retired", retired,       32'd15);
            check("halted_flag",    32'(halted),   32'h1);
            check("halted_req",     32'(imem_req), 32'h0);
            check("halted_pc",      pc,            32'h4);
        end
        exec_done  = 1'b0;
        imem_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("halt_rst_req", 32'(imem_req), 32'h0);
        tick();
        check("halt_rst_halted",  32'(halted), 32'h0);
        check("halt_rst_pc",      pc,          32'h0);
        check("halt_rst_retired", retired,     32'h0);
        check("halt_rst_instr",   instr,       32'h0);
        rst = 1'b0;
        #1;
        check("halt_rel_req",  32'(imem_req), 32'h1);
        check("halt_rel_addr", imem_addr,     32'h0);

        // Reset mid-fetch with ready coinciding: the word must not load.
        tick();
        tick();
        check("midfetch_addr", imem_addr, 32'h0);
        rst        = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'h0000_0020;
        tick();
        rst        = 1'b0;
        imem_ready = 1'b0;
        #1;
        check("midfetch_valid", 32'(instr_valid), 32'h0);
        check("midfetch_instr", instr,            32'h0);
        check("midfetch_req",   32'(imem_req),    32'h1);

        // Reset in ISSUE coinciding with exec_done: no retirement.
        imem_ready = 1'b1;
        imem_rdata = 32'h0000_0020;
        tick();
        imem_ready = 1'b0;
        check("rst_issue_valid", 32'(instr_valid), 32'h1);
        rst       = 1'b1;
        exec_done = 1'b1;
        tick();
        rst       = 1'b0;
        exec_done = 1'b0;
        #1;
        check("rst_issue_retired", retired,          32'h0);
        check("rst_issue_valid2",  32'(instr_valid), 32'h0);
        check("rst_issue_instr",   instr,            32'h0);
        check("rst_issue_req",     32'(imem_req),    32'h1);
        check("rst_issue_addr",    imem_addr,        32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the single-issue MIPS-style processor. Holds the program counter, fetches one 32-bit word per instruction from instruction memory through a req/ready handshake, and latches it in an instruction register. It presents `Opcode` and the full instruction to the control unit and datapath, then computes the next PC from the `Branch`/`Jump` decisions and the ALU `Zero` flag once the datapath signals completion.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset. Must be a multiple of 4.
- `clk`  in  1  Single clock. All state updates on the rising edge.
- `rst`  in  1  Reset, synchronous and active-high.
- `imem_req`  out  1  Fetch request to instruction memory.
- `imem_addr`  out  32  Fetch address; equals `pc` whenever `imem_req`=1.
- `imem_rdata`  in  32  Instruction word; sampled when `imem_req`&`imem_ready`.
- `imem_ready`  in  1  Memory has valid data this cycle. Combinational, same-cycle response.
- `exec_done`  in  1  Datapath has finished the issued instruction; `Branch`/`Jump`/`Zero` are valid this cycle.
- `Branch`  in  1  From the control unit.
- `Jump`  in  1  From the control unit.
- `Zero`  in  1  ALU zero flag.
- `instr`  out  32  Instruction register.
- `Opcode`  out  6  `instr[31:26]`, drives the control unit.
- `instr_valid`  out  1  `instr` holds an issued instruction awaiting `exec_done`.
- `pc`  out  32  Address of the current instruction.
- `pc_plus4`  out  32  `pc + 4`, modulo 2^32.
- `halted`  out  1  A halt instruction was fetched; the stage is frozen.
- `retired`  out  32  Count of instructions completed by `exec_done`. Wraps modulo 2^32.

## Operation
- State machine with three states:
  - **FETCH**: `imem_req`=1 and `imem_addr`=`pc`, with both held stable until `imem_ready`. On `imem_ready`=1:
    - If `imem_rdata[31:26]`=6'h3F, go to HALTED. `instr` is loaded.
    - Otherwise load `instr` from `imem_rdata` and go to ISSUE.
  - **ISSUE**: `imem_req`=0 and `instr_valid`=1. On `exec_done`=1:
    - Load `pc` with the next PC.
    - Increment `retired`.
    - Return to FETCH.
  - **HALTED**: `halted`=1, `imem_req`=0, `instr_valid`=0. All inputs are ignored. Only `rst` exits this state.
- Next PC calculation, in priority order:
  1. `Jump`=1: `{pc_plus4[31:28], instr[25:0], 2'b00}`.
  2. `Branch`&`Zero`: `pc_plus4 + (sign_extend(instr[15:0]) << 2)`, 32-bit and wrapping.
  3. Otherwise: `pc_plus4`.
- `Branch`=1 with `Zero`=0 means not taken, so the next PC is `pc_plus4`.
- `pc[1:0]` is always 2'b00.
- Input sampling rules:
  - `exec_done` is ignored outside ISSUE.
  - `imem_ready` and `imem_rdata` are ignored outside FETCH.
  - `Branch`, `Jump` and `Zero` are sampled only in the `exec_done` cycle.
- Reset values: state FETCH, `pc`=`RESET_PC`, `instr`=0, `instr_valid`=0, `halted`=0, `retired`=0.
  - `imem_req` is 0 during the `rst` cycle and 1 in the first cycle after release.
- Reset in any state, including mid-fetch with `imem_ready` low, ISSUE or HALTED, abandons the operation. Any `imem_ready` or `exec_done` coinciding with `rst` is ignored.

## Timing
- Fetch completes in the same cycle that `imem_ready` is high. `instr_valid` rises on the next edge.
- Zero-wait memory with `exec_done` asserted immediately gives 2 cycles per instruction: one FETCH cycle, one ISSUE cycle.
- Each memory wait state adds one cycle in FETCH. Each cycle without `exec_done` adds one cycle in ISSUE.
- `Opcode` is registered and stable for the entire ISSUE period. The control unit decodes it combinationally.
- On the `exec_done` edge, the new `pc` and incremented `retired` are visible in the next cycle, together with `imem_req`=1.
- Counter and PC overflow: `pc`=32'hFFFF_FFFC sequential → 32'h0000_0000. `retired`=32'hFFFF_FFFF → 0.

## Test plan
- Reset with `RESET_PC`=0, then release; memory returns 32'h0000_0020 (R-type) with ready; `exec_done`, `Branch`=`Jump`=0 → `instr_valid` high 1 cycle after ready, next `imem_addr`=32'h4, `retired`=1.
- Wait states: at `pc`=32'h4, hold `imem_ready` low for 3 cycles → `imem_addr` stays 32'h4 and `instr_valid`=0 throughout; ready on the 4th cycle → `instr_valid`=1 on the next cycle.
- Branch: at `pc`=32'h10, `instr`=32'h4000_FFFE. With `Branch`=1, `Zero`=1 → next `imem_addr`=32'h0C. Repeat with `Zero`=0 → 32'h14.
- Jump priority: at `pc`=32'h20, `instr`=32'h8000_0040, `Jump`=1, `Branch`=1, `Zero`=1 → next addr 32'h100. At `pc`=32'hF000_0000 with the same instr → 32'hF000_0100.
- Halt: fetch 32'hFC00_0000 → `halted`=1 and `imem_req`=0 from the next cycle; `exec_done` pulses do not change `retired`; `rst` → `halted`=0 and addr=`RESET_PC`.
- Boundary: force `pc`=32'hFFFF_FFFC, sequential `exec_done` → addr 32'h0. Assert `rst` in ISSUE coincident with `exec_done` → `retired` is not incremented, and `imem_addr`=`RESET_PC` in the first cycle after release.
